// File: rtl/spi_cmd_frame_decoder.sv
// SPI-slave command frame decoder: deserialises opcode+payload frames, decodes SPIN/WIN/UPDATE/NOP
// and shifts a status word back on sdo. Optional frame parity via `SPI_CMD_PARITY_EN.
module spi_cmd_frame_decoder #(
  parameter int NUM_REELS = 3,
  parameter int IDX_W     = 4,
  parameter int OP_W      = 4,
  parameter int PAYLOAD_W = 12
) (
  input  logic                       sclk,
  input  logic                       reset,
  input  logic                       cs,
  input  logic                       sdi,
  output logic                       sdo,
  output logic [NUM_REELS*IDX_W-1:0] reel_idx,
  output logic [PAYLOAD_W-1:0]       win_credits,
  output logic [PAYLOAD_W-1:0]       total_credits,
  output logic                       is_spin,
  output logic                       is_win,
  output logic                       is_total,
  output logic                       cmd_toggle,
  output logic                       err
);

`ifdef SPI_CMD_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int FRAME_W = OP_W + PAYLOAD_W + PAR_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam int REEL_W  = NUM_REELS * IDX_W;

  if (REEL_W > PAYLOAD_W || PAYLOAD_W < 5) begin : g_param_check
    $error("spi_cmd_frame_decoder: need NUM_REELS*IDX_W <= PAYLOAD_W and PAYLOAD_W >= 5");
  end

  logic [FRAME_W-2:0]   rx;
  logic [CNT_W-1:0]     bit_cnt;
  logic [FRAME_W-1:0]   frame;
  logic [FRAME_W-1:0]   status;
  logic [FRAME_W-1:0]   status_next;
  logic [3:0]           frame_seq;
  logic [3:0]           seq_next;
  logic [OP_W-1:0]      op;
  logic [PAYLOAD_W-1:0] payload;
  logic                 done;
  logic                 saturated;
  logic                 parity_ok;
  logic                 is_cmd;
  logic                 is_nop;
  logic                 accept;
  logic                 err_next;

  assign frame     = {rx, sdi};
  assign op        = frame[FRAME_W-1 -: OP_W];
  assign payload   = frame[FRAME_W-1-OP_W -: PAYLOAD_W];
  assign done      = (bit_cnt == CNT_W'(FRAME_W - 1));
  assign saturated = (bit_cnt == CNT_W'(FRAME_W));

`ifdef SPI_CMD_PARITY_EN
  assign parity_ok = ~(^frame);
`else
  assign parity_ok = 1'b1;
`endif

  assign is_cmd   = (op == OP_W'(1)) || (op == OP_W'(2)) || (op == OP_W'(3));
  assign is_nop   = (op == OP_W'(0));
  assign accept   = parity_ok && is_cmd;
  assign err_next = !parity_ok || (!is_cmd && !is_nop);
  assign seq_next = accept ? frame_seq + 4'd1 : frame_seq;

  always_comb begin
    status_next = '0;
    status_next[FRAME_W-1 -: OP_W]   = op;
    status_next[FRAME_W-1-OP_W]      = err_next;
    status_next[FRAME_W-2-OP_W -: 4] = seq_next;
  end

  // Once the frame is complete, the master clocks out zeros until cs rises.
  assign sdo = status[FRAME_W-1] & ~saturated;

  // Frame receive path; cs high acts as an asynchronous clear.
  always_ff @(posedge sclk or negedge reset or posedge cs) begin
    if (!reset) begin
      rx      <= '0;
      bit_cnt <= '0;
    end else if (cs) begin
      rx      <= '0;
      bit_cnt <= '0;
    end else if (!saturated) begin
      rx      <= {rx[FRAME_W-3:0], sdi};
      bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      status        <= '0;
      frame_seq     <= '0;
      err           <= 1'b0;
      reel_idx      <= '0;
      win_credits   <= '0;
      total_credits <= '0;
      is_spin       <= 1'b0;
      is_win        <= 1'b0;
      is_total      <= 1'b0;
      cmd_toggle    <= 1'b0;
    end else if (!cs) begin
      if (done) begin
        status    <= status_next;
        err       <= err_next;
        frame_seq <= seq_next;
        if (accept) begin
          cmd_toggle <= ~cmd_toggle;
          is_spin    <= (op == OP_W'(1));
          is_win     <= (op == OP_W'(2));
          is_total   <= (op == OP_W'(3));
          if (op == OP_W'(1)) reel_idx      <= payload[REEL_W-1:0];
          if (op == OP_W'(2)) win_credits   <= payload;
          if (op == OP_W'(3)) total_credits <= payload;
        end
      end else if (!saturated) begin
        status <= {status[FRAME_W-2:0], 1'b0};
      end
    end
  end

endmodule
